regfile_write_arbiter: RTL and testbench

Shares the single write port (D, DA, W) of the 32x64 register file between two writeback requesters, the ALU result path and the memory-load path. It arbitrates round-robin, registers the winning write onto the register file port, and drops writes to the zero register R31. It also keeps a 32-bit pending-write scoreboard that the issue logic uses for hazard checks. It sits between the execute/memory stages and the register file; read ports SA/SB/A/B are untouched.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 47 ++++
 rtl/regfile_write_arbiter.sv | 115 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared constants and types for the 32x64 register file and its write-side
// logic. The register file, the write arbiter and their benches all import
// this package so the geometry is defined in exactly one place.
//   DATA_WIDTH : register data width
//   ADDR_WIDTH : register address width
//   NUM_REGS   : number of registers (2**ADDR_WIDTH)
//   ZERO_REG   : hardwired-zero register; writes to it are discarded
//   req_id_t   : identifies a writeback requester (ALU result or memory load)
package regfile_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 31;

   // Encoding doubles as the grant/request bit index: bit 0 = ALU, bit 1 = MEM.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. When both requesters ask, the one that did not
// win the most recent accepted transfer is granted, so a requester that stays
// valid waits at most one cycle.
//   clk    : clock, all state on the rising edge
//   srst   : synchronous active-high reset (priority returns to "MEM won last")
//   req    : request vector, bit 0 = ALU, bit 1 = MEM
//   accept : a granted request actually transferred this cycle
//   gnt    : one-hot (or zero) grant vector, combinational from req and state
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk,
   input  logic       srst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   req_id_t last_grant_reg;
   req_id_t last_grant_next;

   always_ff @(posedge clk) begin
      if (srst) begin
         // "MEM won last" makes the ALU win the first tie after reset.
         last_grant_reg <= REQ_MEM;
      end else begin
         last_grant_reg <= last_grant_next;
      end
   end

   always_comb begin
      gnt             = 2'b00;
      last_grant_next = last_grant_reg;
      if (req == 2'b11) begin
         gnt = (last_grant_reg == REQ_ALU) ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
      // Priority only moves when a transfer really happens; a grant that is
      // masked (e.g. by reset) must not rotate the priority.
      if (accept) begin
         last_grant_next = gnt[1] ? REQ_MEM : REQ_ALU;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single register-file write port between the ALU writeback path
// and the memory-load path. Arbitrates round-robin, registers the winning
// write onto D/DA/W, drops writes to the zero register, and keeps a pending
// write scoreboard for the issue logic's hazard checks.
//   clock, reset            : clock and synchronous active-high reset
//   alu_valid/ready/addr/data : ALU writeback request (valid/ready handshake)
//   mem_valid/ready/addr/data : load writeback request (valid/ready handshake)
//   reserve_valid/addr      : issue logic marks a destination register pending
//   rf_D, rf_DA, rf_W       : register file write data, address and enable
//   busy                    : bit i set while register i has a write pending
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH,
   parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
   parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   input  logic                  reserve_valid,
   input  logic [ADDR_WIDTH-1:0] reserve_addr,
   output logic [DATA_WIDTH-1:0] rf_D,
   output logic [ADDR_WIDTH-1:0] rf_DA,
   output logic                  rf_W,
   output logic [NUM_REGS-1:0]   busy
);

   import regfile_pkg::*;

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   logic [1:0]            gnt;
   logic                  xfer;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;

   logic [DATA_WIDTH-1:0] rf_d_reg;
   logic [ADDR_WIDTH-1:0] rf_da_reg;
   logic                  rf_w_reg;
   logic [NUM_REGS-1:0]   busy_reg;

   rr_arbiter2 u_arb (
      .clk    (clock),
      .srst   (reset),
      .req    ({mem_valid, alu_valid}),
      .accept (xfer),
      .gnt    (gnt)
   );

   // Ready is masked during reset so nothing is accepted on a reset edge.
   // It deliberately ignores rf_W: the register file never back-pressures.
   assign alu_ready = gnt[REQ_ALU] & ~reset;
   assign mem_ready = gnt[REQ_MEM] & ~reset;
   assign xfer      = alu_ready | mem_ready;

   assign win_addr = mem_ready ? mem_addr : alu_addr;
   assign win_data = mem_ready ? mem_data : alu_data;

   always_ff @(posedge clock) begin
      if (reset) begin
         rf_d_reg  <= '0;
         rf_da_reg <= '0;
         rf_w_reg  <= 1'b0;
      end else if (xfer) begin
         rf_d_reg  <= win_data;
         rf_da_reg <= win_addr;
         // A zero-register write completes its handshake but never strobes W.
         rf_w_reg  <= (win_addr != ZERO_ADDR);
      end else begin
         rf_w_reg  <= 1'b0;
      end
   end

   // Scoreboard: one flop per register. The clear is keyed off the registered
   // write so the bit falls on the same edge the register file captures data.
   // A reservation on that same edge belongs to a newer producer, so set wins.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
         if (gi == ZERO_REG) begin : g_zero
            always_ff @(posedge clock) begin
               busy_reg[gi] <= 1'b0;
            end
         end else begin : g_bit
            logic set_bit;
            logic clr_bit;
            assign set_bit = reserve_valid && (reserve_addr == ADDR_WIDTH'(gi));
            assign clr_bit = rf_w_reg && (rf_da_reg == ADDR_WIDTH'(gi));
            always_ff @(posedge clock) begin
               if (reset) begin
                  busy_reg[gi] <= 1'b0;
               end else if (set_bit) begin
                  busy_reg[gi] <= 1'b1;
               end else if (clr_bit) begin
                  busy_reg[gi] <= 1'b0;
               end
            end
         end
      end
   endgenerate

   assign rf_D  = rf_d_reg;
   assign rf_DA = rf_da_reg;
   assign rf_W  = rf_w_reg;
   assign busy  = busy_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   import regfile_pkg::*;

   logic                  clock;
   logic                  reset;
   logic                  alu_valid;
   logic                  alu_ready;
   logic [ADDR_WIDTH-1:0] alu_addr;
   logic [DATA_WIDTH-1:0] alu_data;
   logic                  mem_valid;
   logic                  mem_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  reserve_valid;
   logic [ADDR_WIDTH-1:0] reserve_addr;
   logic [DATA_WIDTH-1:0] rf_D;
   logic [ADDR_WIDTH-1:0] rf_DA;
   logic                  rf_W;
   logic [NUM_REGS-1:0]   busy;

   int errors = 0;
   int checks = 0;

   regfile_write_arbiter dut (
      .clock         (clock),
      .reset         (reset),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_addr      (alu_addr),
      .alu_data      (alu_data),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_addr      (mem_addr),
      .mem_data      (mem_data),
      .reserve_valid (reserve_valid),
      .reserve_addr  (reserve_addr),
      .rf_D          (rf_D),
      .rf_DA         (rf_DA),
      .rf_W          (rf_W),
      .busy          (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Simple register file model fed by the write port, so register contents
   // can be checked the way the rest of the core would see them.
   logic [DATA_WIDTH-1:0] rf_mem [NUM_REGS];
   logic                  rf_clear;
   always @(posedge clock) begin
      if (rf_clear) begin
         for (int i = 0; i < NUM_REGS; i++) rf_mem[i] <= '0;
      end else if (rf_W) begin
         rf_mem[rf_DA] <= rf_D;
      end
   end

   typedef struct {
      logic                  av;
      logic [ADDR_WIDTH-1:0] aa;
      logic [DATA_WIDTH-1:0] ad;
      logic                  mv;
      logic [ADDR_WIDTH-1:0] ma;
      logic [DATA_WIDTH-1:0] md;
      logic                  rv;
      logic [ADDR_WIDTH-1:0] ra;
      logic                  e_ar;
      logic                  e_mr;
      logic                  e_w;
      logic [ADDR_WIDTH-1:0] e_da;
      logic [DATA_WIDTH-1:0] e_d;
      logic [NUM_REGS-1:0]   e_busy;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   function automatic vec_t mk(logic av, int aa, logic [63:0] ad,
                               logic mv, int ma, logic [63:0] md,
                               logic rv, int ra,
                               logic e_ar, logic e_mr, logic e_w, int e_da,
                               logic [63:0] e_d, logic [31:0] e_busy);
      vec_t v;
      v.av = av; v.aa = ADDR_WIDTH'(aa); v.ad = ad;
      v.mv = mv; v.ma = ADDR_WIDTH'(ma); v.md = md;
      v.rv = rv; v.ra = ADDR_WIDTH'(ra);
      v.e_ar = e_ar; v.e_mr = e_mr; v.e_w = e_w; v.e_da = ADDR_WIDTH'(e_da);
      v.e_d = e_d; v.e_busy = e_busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input int aa, input logic [63:0] ad,
                        input logic mv, input int ma, input logic [63:0] md,
                        input logic rv, input int ra);
      alu_valid = av; alu_addr = ADDR_WIDTH'(aa); alu_data = ad;
      mem_valid = mv; mem_addr = ADDR_WIDTH'(ma); mem_data = md;
      reserve_valid = rv; reserve_addr = ADDR_WIDTH'(ra);
   endtask

   localparam logic [63:0] D5  = 64'hDEADBEEF_00000001;
   localparam logic [31:0] B7  = 32'h0000_0080;
   localparam logic [31:0] B9  = 32'h0000_0200;

   initial begin
      // av aa ad        mv ma md      rv ra  ar mr w  da d          busy
      vecs[0]  = mk(1, 5, D5,       0, 0, 64'h0,  0, 0,  1, 0, 1, 5,  D5,        32'h0);
      vecs[1]  = mk(0, 0, 64'h0,    1, 3, 64'h33, 0, 0,  0, 1, 1, 3,  64'h33,    32'h0);
      vecs[2]  = mk(1, 1, 64'hA1,   1, 2, 64'hB2, 0, 0,  1, 0, 1, 1,  64'hA1,    32'h0);
      vecs[3]  = mk(1, 1, 64'hA1,   1, 2, 64'hB2, 0, 0,  0, 1, 1, 2,  64'hB2,    32'h0);
      vecs[4]  = mk(1, 1, 64'hA1,   1, 2, 64'hB2, 0, 0,  1, 0, 1, 1,  64'hA1,    32'h0);
      vecs[5]  = mk(1, 1, 64'hA1,   1, 2, 64'hB2, 0, 0,  0, 1, 1, 2,  64'hB2,    32'h0);
      vecs[6]  = mk(1, 1, 64'hA1,   1, 2, 64'hB2, 0, 0,  1, 0, 1, 1,  64'hA1,    32'h0);
      vecs[7]  = mk(1, 1, 64'hA1,   1, 2, 64'hB2, 0, 0,  0, 1, 1, 2,  64'hB2,    32'h0);
      vecs[8]  = mk(1, 31, 64'hFFFF, 0, 0, 64'h0, 0, 0,  1, 0, 0, 31, 64'hFFFF,  32'h0);
      vecs[9]  = mk(0, 0, 64'h0,    0, 0, 64'h0,  1, 7,  0, 0, 0, 31, 64'hFFFF,  B7);
      vecs[10] = mk(0, 0, 64'h0,    0, 0, 64'h0,  1, 31, 0, 0, 0, 31, 64'hFFFF,  B7);
      vecs[11] = mk(0, 0, 64'h0,    1, 7, 64'h77, 0, 0,  0, 1, 1, 7,  64'h77,    B7);
      vecs[12] = mk(0, 0, 64'h0,    0, 0, 64'h0,  0, 0,  0, 0, 0, 7,  64'h77,    32'h0);
      vecs[13] = mk(0, 0, 64'h0,    0, 0, 64'h0,  1, 7,  0, 0, 0, 7,  64'h77,    B7);
      vecs[14] = mk(0, 0, 64'h0,    1, 7, 64'h78, 0, 0,  0, 1, 1, 7,  64'h78,    B7);
      vecs[15] = mk(0, 0, 64'h0,    0, 0, 64'h0,  1, 7,  0, 0, 0, 7,  64'h78,    B7);
      vecs[16] = mk(1, 7, 64'h79,   1, 4, 64'h44, 0, 0,  1, 0, 1, 7,  64'h79,    B7);
      vecs[17] = mk(0, 0, 64'h0,    1, 4, 64'h44, 0, 0,  0, 1, 1, 4,  64'h44,    32'h0);

      // Reset with both requesters valid: nothing may be accepted.
      rf_clear = 1'b1;
      reset = 1'b1;
      drive(1, 5, 64'h55, 1, 6, 64'h66, 1, 8);
      @(posedge clock);
      @(negedge clock);
      chk("reset alu_ready", 64'(alu_ready), 64'h0);
      chk("reset mem_ready", 64'(mem_ready), 64'h0);
      chk("reset rf_W", 64'(rf_W), 64'h0);
      chk("reset rf_DA", 64'(rf_DA), 64'h0);
      chk("reset rf_D", rf_D, 64'h0);
      chk("reset busy", 64'(busy), 64'h0);
      $display("txn reset: rf_W=%0b rf_DA=%0d busy=%h", rf_W, rf_DA, busy);
      reset = 1'b0;
      rf_clear = 1'b0;
      drive(0, 0, 64'h0, 0, 0, 64'h0, 0, 0);

      for (int i = 0; i < NV; i++) begin
         @(negedge clock);
         drive(vecs[i].av, int'(vecs[i].aa), vecs[i].ad, vecs[i].mv, int'(vecs[i].ma),
               vecs[i].md, vecs[i].rv, int'(vecs[i].ra));
         #1;
         chk($sformatf("v%0d alu_ready", i), 64'(alu_ready), 64'(vecs[i].e_ar));
         chk($sformatf("v%0d mem_ready", i), 64'(mem_ready), 64'(vecs[i].e_mr));
         @(posedge clock);
         #1;
         chk($sformatf("v%0d rf_W", i), 64'(rf_W), 64'(vecs[i].e_w));
         chk($sformatf("v%0d rf_DA", i), 64'(rf_DA), 64'(vecs[i].e_da));
         chk($sformatf("v%0d rf_D", i), rf_D, vecs[i].e_d);
         chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].e_busy));
         $display("txn v%0d: ready a/m=%0b/%0b rf_W=%0b rf_DA=%0d rf_D=%h busy=%h",
                  i, vecs[i].e_ar, vecs[i].e_mr, rf_W, rf_DA, rf_D, busy);
      end

      @(negedge clock);
      drive(0, 0, 64'h0, 0, 0, 64'h0, 0, 0);
      @(negedge clock);
      chk("R05 contents", rf_mem[5], D5);
      chk("R31 untouched", rf_mem[31], 64'h0);
      chk("R07 contents", rf_mem[7], 64'h79);
      chk("R04 contents", rf_mem[4], 64'h44);
      $display("txn regs: R05=%h R31=%h R07=%h R04=%h", rf_mem[5], rf_mem[31], rf_mem[7], rf_mem[4]);

      // ALU wins, reserve 9 -> priority now "ALU won last", busy[9] set.
      drive(1, 10, 64'hA10, 0, 0, 64'h0, 1, 9);
      #1;
      chk("pre alu_ready", 64'(alu_ready), 64'h1);
      @(posedge clock);
      #1;
      chk("pre rf_DA", 64'(rf_DA), 64'd10);
      chk("pre busy", 64'(busy), 64'(B9));
      $display("txn pre-reset: rf_DA=%0d busy=%h", rf_DA, busy);

      // ALU write to 9 presented on a reset edge must be dropped.
      @(negedge clock);
      reset = 1'b1;
      drive(1, 9, 64'h99, 1, 2, 64'h22, 0, 0);
      #1;
      chk("rst alu_ready", 64'(alu_ready), 64'h0);
      chk("rst mem_ready", 64'(mem_ready), 64'h0);
      @(posedge clock);
      #1;
      chk("rst rf_W", 64'(rf_W), 64'h0);
      chk("rst busy", 64'(busy), 64'h0);
      $display("txn reset-drop: rf_W=%0b busy=%h", rf_W, busy);

      // First tie after reset goes to the ALU.
      @(negedge clock);
      reset = 1'b0;
      drive(1, 3, 64'h333, 1, 4, 64'h444, 0, 0);
      #1;
      chk("tie alu_ready", 64'(alu_ready), 64'h1);
      chk("tie mem_ready", 64'(mem_ready), 64'h0);
      @(posedge clock);
      #1;
      chk("tie rf_DA", 64'(rf_DA), 64'd3);
      chk("tie rf_W", 64'(rf_W), 64'h1);
      @(negedge clock);
      drive(0, 0, 64'h0, 0, 0, 64'h0, 0, 0);
      @(negedge clock);
      chk("R09 unchanged", rf_mem[9], 64'h0);
      $display("txn post-reset tie: rf_DA=3 R09=%h", rf_mem[9]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
